tb_run_ctrl: RTL
================

TB_RUN_CTRL -- requirements
Module: tb_run_ctrl

Interface
REQ-001 Parameter DATA_W, default 64, memory word width in bits.
REQ-002 Parameter ADDR_W, default 12, word-address width.
REQ-003 Parameter DEPTH, default 64, words zeroed before load; 1..2^ADDR_W.
REQ-004 Parameter HOLD_CYC, default 8, cycles CPU reset is held after load; minimum 1.
REQ-005 Parameter TIMEOUT_CYC, default 5000000, RUN-cycle limit before timeout.
REQ-006 Parameter DONE_ADDR, default all-ones, word address whose write ends the test.
REQ-007 Ports (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge;
 reset  in  1  asynchronous, active-low;
 img_words  in  ADDR_W+1  number of image words to load, 0..DEPTH, sampled on leaving reset;
 img_addr  out  ADDR_W  image ROM read address;
 img_data  in  DATA_W  ROM data, valid one cycle after img_addr;
 mem_wr_valid  out  1  memory write request;
 mem_wr_ready  in  1  memory accepts write when valid&ready;
 mem_wr_addr  out  ADDR_W  write word address;
 mem_wr_data  out  DATA_W  write data;
 cpu_reset  out  1  active-high reset to the CPU;
 mon_wr_valid  in  1  CPU store observed;
 mon_wr_addr  in  ADDR_W  CPU store word address;
 mon_wr_data  in  DATA_W  CPU store data;
 done  out  1  test finished (pass, fail or timeout);
 pass  out  1  valid when done;
 timeout  out  1  valid when done;
 cycles  out  32  RUN-state cycle count, saturating.

Function
REQ-008 States SHALL be CLEAR, LOAD, HOLD, RUN, DONE; one-hot or binary at implementer's choice.
REQ-009 CLEAR SHALL issue writes of zero to addresses 0..DEPTH-1 in order; address advances only on valid&ready.
REQ-010 mem_wr_valid, once asserted, SHALL hold with stable addr/data until ready.
REQ-011 After the write to DEPTH-1 is accepted, CLEAR SHALL go to LOAD, or directly to HOLD if img_words=0.
REQ-012 LOAD SHALL write img_data from image address k to memory address k for k=0..img_words-1, accounting for the one-cycle ROM latency and for backpressure without dropping or duplicating words.
REQ-013 LOAD SHALL sustain one write per cycle while mem_wr_ready stays high.
REQ-014 After the last LOAD write is accepted, the FSM SHALL enter HOLD.
REQ-015 cpu_reset SHALL be 1 in CLEAR, LOAD and HOLD, and SHALL be 1 for exactly HOLD_CYC cycles in HOLD; then 0 in RUN.
REQ-016 In RUN, cycles SHALL increment every clock, saturating at 2^32-1.
REQ-017 In RUN, mon_wr_valid with mon_wr_addr=DONE_ADDR SHALL move to DONE next cycle; pass=1 iff mon_wr_data[0]=1.
REQ-018 In RUN, if cycles reaches TIMEOUT_CYC with no done write, the FSM SHALL enter DONE with timeout=1, pass=0; a done write in that same cycle takes priority over timeout.
REQ-019 In DONE, done=1; pass, timeout and cycles SHALL be frozen; cpu_reset SHALL return to 1; DONE is left only by reset.
REQ-020 mon_wr_* SHALL be ignored outside RUN.
REQ-021 mem_wr_valid SHALL be 0 in HOLD, RUN and DONE.

Reset
REQ-022 reset low SHALL asynchronously force state CLEAR with address 0, and set mem_wr_valid=0, cpu_reset=1, done=0, pass=0, timeout=0, cycles=0, img_addr=0.
REQ-023 reset asserted mid-operation (any state) SHALL abort any pending write and restart from CLEAR on release; img_words is resampled.
REQ-024 The first write request SHALL appear no earlier than the first rising edge after reset deasserts.

Structure
REQ-025 A shared package SHALL hold the state encoding and the default DONE_ADDR/TIMEOUT constants for reuse by other benches.
REQ-026 The load datapath (ROM-latency skid register plus write-request holding register) SHALL be one sub-module, tb_load_skid.

Verification
REQ-027 DEPTH=64, img_words=4, ready always 1 -> 64 zero writes at 0..63, then 4 image writes, data matching ROM, in 68 consecutive cycles; cpu_reset falls HOLD_CYC cycles after the last write.
REQ-028 ready toggling 1,0,0,1 pseudo-randomly during LOAD -> every image word written exactly once, in order, with no data corruption.
REQ-029 In RUN, store to DONE_ADDR with data 1 at cycle 100 -> done=1, pass=1, timeout=0, cycles=100 frozen; cpu_reset=1.
REQ-030 TIMEOUT_CYC=50, no done write -> done=1, timeout=1, pass=0 at cycles=50; store to DONE_ADDR on that same cycle with data 0 -> pass=0, timeout=0.
REQ-031 reset pulsed low during LOAD word 2 -> all outputs at reset values immediately; after release a full CLEAR of 64 words restarts from address 0.
REQ-032 img_words=0 -> CLEAR followed directly by HOLD; no LOAD writes issued.

Source files
------------

// File: rtl/tb_run_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : tb_run_ctrl_pkg
// Brief  : Shared state encoding and default constants for the test-run
//          controller, importable by other benches.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package tb_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  localparam int unsigned DEF_TIMEOUT_CYC = 5000000;
  localparam int          DEF_ADDR_W      = 12;
  localparam logic [DEF_ADDR_W-1:0] DEF_DONE_ADDR = '1;

  // 32-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tb_load_skid.sv
//------------------------------------------------------------------------------
// Module : tb_load_skid
// Brief  : Image-load datapath. Issues ROM reads, catches the one-cycle-late
//          ROM data in a skid register and presents it through a write-request
//          holding register that stays stable under backpressure.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_skid #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W:0]   words,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_accept
);

  logic [ADDR_W:0]   rd_cnt;
  logic              rd_pend;
  logic              sk_valid;
  logic [DATA_W-1:0] sk_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   wr_cnt;
  logic              out_free;
  logic              sk_valid_nx;
  logic              issue;

  assign img_addr    = rd_cnt[ADDR_W-1:0];
  assign wr_valid    = out_valid;
  assign wr_addr     = wr_cnt[ADDR_W-1:0];
  assign wr_data     = out_data;
  assign last_accept = out_valid && wr_ready && (wr_cnt == words - (ADDR_W+1)'(1));

  // A read may only be issued when the skid will be empty next cycle, so the
  // returning word always has somewhere to land.
  always_comb begin
    out_free    = !out_valid || wr_ready;
    sk_valid_nx = sk_valid;
    if (out_free) begin
      sk_valid_nx = sk_valid && rd_pend;
    end else begin
      sk_valid_nx = sk_valid || rd_pend;
    end
    issue = enable && (rd_cnt < words) && !sk_valid_nx;
  end

  // Read counter, skid register and output holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt    <= '0;
      rd_pend   <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_cnt    <= '0;
    end else begin
      rd_pend  <= issue;
      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (out_free) begin
        if (sk_valid) begin
          out_valid <= 1'b1;
          out_data  <= sk_data;
          if (rd_pend) begin
            sk_data <= img_data;
          end
        end else if (rd_pend) begin
          out_valid <= 1'b1;
          out_data  <= img_data;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_data <= img_data;
      end
      sk_valid <= sk_valid_nx;
      if (out_valid && wr_ready) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tb_run_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_run_ctrl
// Brief  : Test-run controller: zeroes memory, loads a program image, holds
//          the CPU in reset, then runs it until a done store or a timeout.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_ctrl
  import tb_run_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                ADDR_W      = 12,
  parameter int                DEPTH       = 64,
  parameter int unsigned       HOLD_CYC    = 8,
  parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [ADDR_W-1:0] DONE_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   img_words,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              cpu_reset,
  input  logic              mon_wr_valid,
  input  logic [ADDR_W-1:0] mon_wr_addr,
  input  logic [DATA_W-1:0] mon_wr_data,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycles
);

  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(DEPTH - 1);

  run_state_t        state, state_nx;
  logic              clr_valid;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W:0]   words_q;
  logic [31:0]       hold_cnt;
  logic              clr_last;
  logic              done_hit;
  logic              timed_out;
  logic              ld_enable;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  assign clr_last  = clr_valid && mem_wr_ready && (clr_addr == LAST_CLR);
  assign done_hit  = mon_wr_valid && (mon_wr_addr == DONE_ADDR);
  assign timed_out = (cycles >= TIMEOUT_CYC);
  assign done      = (state == ST_DONE);
  // Prefetch the first image words while CLEAR is still running so LOAD
  // follows the last zero write without a bubble.
  assign ld_enable = ((state == ST_CLEAR) && clr_valid) || (state == ST_LOAD);
  assign ld_ready  = mem_wr_ready && (state == ST_LOAD);

  tb_load_skid #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_load (
    .clk         (clk),
    .reset       (reset),
    .enable      (ld_enable),
    .words       (words_q),
    .img_addr    (img_addr),
    .img_data    (img_data),
    .wr_valid    (ld_valid),
    .wr_ready    (ld_ready),
    .wr_addr     (ld_addr),
    .wr_data     (ld_data),
    .last_accept (ld_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and memory-write / CPU-reset output steering
  always_comb begin
    state_nx     = state;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    cpu_reset    = 1'b1;
    case (state)
      ST_CLEAR: begin
        mem_wr_valid = clr_valid;
        mem_wr_addr  = clr_addr;
        if (clr_last) begin
          state_nx = (words_q == '0) ? ST_HOLD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        mem_wr_valid = ld_valid;
        mem_wr_addr  = ld_addr;
        mem_wr_data  = ld_data;
        if (ld_last) begin
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_CYC - 32'd1) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (done_hit || timed_out) begin
          state_nx = ST_DONE;
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  // Clear sequencer, hold timer, run counter and result flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_valid <= 1'b0;
      clr_addr  <= '0;
      words_q   <= '0;
      hold_cnt  <= '0;
      cycles    <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        if (!clr_valid) begin
          clr_valid <= 1'b1;
          words_q   <= img_words;
        end else if (mem_wr_ready) begin
          if (clr_addr == LAST_CLR) begin
            clr_valid <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
      end
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 32'd1 : 32'd0;
      if (state == ST_RUN) begin
        if (done_hit) begin
          pass <= mon_wr_data[0];
        end else if (timed_out) begin
          timeout <= 1'b1;
        end else begin
          cycles <= sat_inc(cycles);
        end
      end
    end
  end

endmodule

`default_nettype wire
